// File: rtl/seq_restoring_divider_cntlr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_restoring_divider_cntlr_pkg
// Description : Shared types and constants for the sequential restoring
//               divider (FSM state encoding, counter sizing, result fill).
// Revision    : 1.0 - initial release
// ============================================================================
package seq_restoring_divider_cntlr_pkg;

    // Controller states; explicit 2-bit encoding keeps the register width fixed.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Each bit of the quotient reported for a divide by zero (all ones).
    localparam logic DBZ_QUOTIENT_FILL = 1'b1;

    // Iteration counter must hold the value n itself, hence n+1 codes.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage : seq_restoring_divider_cntlr_pkg
`default_nettype wire

// File: rtl/seq_restoring_divider_datapath.sv
`default_nettype none
// ============================================================================
// Module      : seq_restoring_divider_datapath
// Description : Remainder/quotient/divisor registers with an N+1-bit trial
//               subtractor. ld_shift=0 loads operands, ld_shift=1 performs one
//               restoring shift-subtract step. q/r present the result of the
//               step that the next shift edge will commit.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_restoring_divider_datapath #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         en,
    input  logic         ld_shift,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] q,
    output logic [N-1:0] r
);

    logic [N-1:0] r_q, r_d;
    logic [N-1:0] q_q, q_d;
    logic [N-1:0] d_q, d_d;
    logic [N:0]   shifted_r;
    logic [N:0]   trial;
    logic [N-1:0] q_step;
    logic [N-1:0] r_step;

    // One restoring step: shift {R,Q} left, trial-subtract D, the borrow
    // (trial sign bit) decides whether to keep the difference or restore.
    always_comb begin
        shifted_r = {r_q, q_q[N-1]};
        trial     = shifted_r - {1'b0, d_q};
        q_step    = {q_q[N-2:0], ~trial[N]};
        r_step    = trial[N] ? shifted_r[N-1:0] : trial[N-1:0];
    end

    assign q = q_step;
    assign r = r_step;

    // Register next-state: hold, load operands, or commit one step.
    always_comb begin
        r_d = r_q;
        q_d = q_q;
        d_d = d_q;
        if (en) begin
            if (ld_shift) begin
                r_d = r_step;
                q_d = q_step;
            end else begin
                r_d = '0;
                q_d = dividend;
                d_d = divisor;
            end
        end
    end

    // Datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_q <= '0;
            q_q <= '0;
            d_q <= '0;
        end else begin
            r_q <= r_d;
            q_q <= q_d;
            d_q <= d_d;
        end
    end

endmodule : seq_restoring_divider_datapath
`default_nettype wire

// File: rtl/seq_restoring_divider_cntlr.sv
`default_nettype none
// ============================================================================
// Module      : seq_restoring_divider_cntlr
// Description : Sequential unsigned restoring divider, one quotient bit per
//               clock. FSM controller plus datapath sub-module; results are
//               held in output registers until the next completion.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_restoring_divider_cntlr
    import seq_restoring_divider_cntlr_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder
);

    localparam int           CW       = cnt_width(N);
    localparam logic [CW-1:0] CNT_INIT = CW'(N);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dbz_q, dbz_d;
    logic [N-1:0]  quot_q, quot_d;
    logic [N-1:0]  rem_q, rem_d;
    logic          dp_en;
    logic          dp_ld_shift;
    logic [N-1:0]  dp_q;
    logic [N-1:0]  dp_r;

    seq_restoring_divider_datapath #(
        .N (N)
    ) u_datapath (
        .clk      (clk),
        .clr_n    (clr_n),
        .en       (dp_en),
        .ld_shift (dp_ld_shift),
        .dividend (dividend),
        .divisor  (divisor),
        .q        (dp_q),
        .r        (dp_r)
    );

    // Next-state, datapath strobes and result capture. The result registers
    // take the datapath's final step value on the edge that enters DONE, so
    // they are valid in the same cycle done is high.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dbz_d       = dbz_q;
        quot_d      = quot_q;
        rem_d       = rem_q;
        dp_en       = 1'b0;
        dp_ld_shift = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dp_en = 1'b1;
                    cnt_d = CNT_INIT;
                    dbz_d = (divisor == '0);
                    if (divisor == '0) begin
                        state_d = ST_DONE;
                        quot_d  = {N{DBZ_QUOTIENT_FILL}};
                        rem_d   = dividend;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                dp_en       = 1'b1;
                dp_ld_shift = 1'b1;
                cnt_d       = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_DONE;
                    quot_d  = dp_q;
                    rem_d   = dp_r;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller and result registers, cleared asynchronously.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
        end
    end

    assign busy        = (state_q == ST_CALC);
    assign done        = (state_q == ST_DONE);
    assign div_by_zero = dbz_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;

endmodule : seq_restoring_divider_cntlr
`default_nettype wire
